// File: rtl/dbus_mmio_responder.sv
// Data-bus MMIO responder: byte RX FIFO fed by an external producer, a free-running
// cycle timer with compare-match, and a level interrupt. Reads are combinational.
module dbus_mmio_responder #(
    parameter logic [31:0] BASE_ADDR       = 32'hFF20_0000,
    parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        DwReadEnable,
    input  logic        DwWriteEnable,
    input  logic [3:0]  DwByteEnable,
    input  logic [31:0] DwAddress,
    input  logic [31:0] DwWriteData,
    output logic [31:0] oReadData,
    output logic        oSelect,
    input  logic        iPushValid,
    input  logic [7:0]  iPushData,
    output logic        oPushReady,
    output logic        oIRQ
);

    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned PW    = FIFO_DEPTH_LOG2;
    localparam int unsigned CW    = FIFO_DEPTH_LOG2 + 1;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_DATA   = 3'd2;
    localparam logic [2:0] OFF_TIMER  = 3'd3;
    localparam logic [2:0] OFF_TCMP   = 3'd4;

    logic          rxie_q, rxie_d, ten_q, ten_d, tie_q, tie_d;
    logic          ovf_q, ovf_d, tmatch_q, tmatch_d;
    logic [31:0]   timer_q, timer_d, tcmp_q, tcmp_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    fifo_mem_q [DEPTH];

    logic        hit, rd_hit, wr_hit, lane0_wr;
    logic [2:0]  off;
    logic        full, not_empty, pop, push, flush, mem_we;
    logic [31:0] rdata;
    logic        unused_addr_lsbs;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    // Address decode; low address bits select bytes inside a word and are not used here
    assign hit              = DwAddress[31:5] == BASE_ADDR[31:5];
    assign off              = DwAddress[4:2];
    assign unused_addr_lsbs = ^DwAddress[1:0];
    assign rd_hit           = DwReadEnable && hit;
    assign wr_hit           = DwWriteEnable && hit;
    assign lane0_wr         = wr_hit && DwByteEnable[0];

    assign full       = count_q == CW'(DEPTH);
    assign not_empty  = count_q != '0;
    assign oSelect    = hit;
    assign oPushReady = !full;
    assign oIRQ       = (rxie_q && not_empty) || (tie_q && tmatch_q);

    // Combinational read mux
    always_comb begin
        rdata = '0;
        if (rd_hit) begin
            case (off)
                OFF_CTRL:   rdata = {28'd0, tie_q, ten_q, 1'b0, rxie_q};
                OFF_STATUS: rdata = 32'({count_q, 4'b0000, tmatch_q, ovf_q, full, not_empty});
                OFF_DATA:   rdata = not_empty ? {24'd0, fifo_mem_q[rd_ptr_q]} : 32'd0;
                OFF_TIMER:  rdata = timer_q;
                OFF_TCMP:   rdata = tcmp_q;
                default:    rdata = '0;
            endcase
        end
    end
    assign oReadData = rdata;

    // Next-state logic; FLUSH overrides any push or pop in the same cycle
    always_comb begin
        rxie_d   = rxie_q;
        ten_d    = ten_q;
        tie_d    = tie_q;
        ovf_d    = ovf_q;
        tmatch_d = tmatch_q;
        timer_d  = ten_q ? timer_q + 32'd1 : timer_q;
        tcmp_d   = tcmp_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        flush  = lane0_wr && (off == OFF_CTRL) && DwWriteData[1];
        pop    = rd_hit && (off == OFF_DATA) && not_empty;
        push   = iPushValid && (!full || pop);
        mem_we = push && !flush;

        if (lane0_wr && (off == OFF_CTRL)) begin
            rxie_d = DwWriteData[0];
            ten_d  = DwWriteData[2];
            tie_d  = DwWriteData[3];
        end
        if (wr_hit && (off == OFF_TIMER)) timer_d = lane_merge(timer_q, DwWriteData, DwByteEnable);
        if (wr_hit && (off == OFF_TCMP))  tcmp_d  = lane_merge(tcmp_q, DwWriteData, DwByteEnable);

        if (lane0_wr && (off == OFF_STATUS)) begin
            if (DwWriteData[2]) ovf_d    = 1'b0;
            if (DwWriteData[3]) tmatch_d = 1'b0;
        end
        if (ten_q && (timer_q == tcmp_q))               tmatch_d = 1'b1;
        if (iPushValid && full && !pop && !flush)       ovf_d    = 1'b1;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            rxie_q   <= 1'b0;
            ten_q    <= 1'b0;
            tie_q    <= 1'b0;
            ovf_q    <= 1'b0;
            tmatch_q <= 1'b0;
            timer_q  <= 32'd0;
            tcmp_q   <= 32'hFFFF_FFFF;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rxie_q   <= rxie_d;
            ten_q    <= ten_d;
            tie_q    <= tie_d;
            ovf_q    <= ovf_d;
            tmatch_q <= tmatch_d;
            timer_q  <= timer_d;
            tcmp_q   <= tcmp_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q
    always_ff @(posedge iCLK) begin
        if (mem_we) fifo_mem_q[wr_ptr_q] <= iPushData;
    end

endmodule
